// File: rtl/food_sprite_renderer.sv
// Food sprite ROM addressing, 3-stage masked pixel pipeline and food lifecycle FSM.
// Food spawns LIVE, enters WARN (blinking) near the end of its lifetime, then expires or is eaten.
module food_sprite_renderer #(
   parameter int                    DATA_WIDTH      = 12,
   parameter int                    ADDR_WIDTH      = 20,
   parameter int                    SPR_W           = 40,
   parameter int                    SPR_H           = 20,
   parameter logic [DATA_WIDTH-1:0] TRANSPARENT     = 12'h0F0,
   parameter int                    LIFETIME_FRAMES = 600,
   parameter int                    BLINK_FRAMES    = 180,
   parameter int                    BLINK_PERIOD    = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_start,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  spawn,
   input  logic [9:0]            spawn_x,
   input  logic [9:0]            spawn_y,
   input  logic                  eaten,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  food_active,
   output logic                  food_pixel_valid,
   output logic [DATA_WIDTH-1:0] food_rgb,
   output logic                  expired
);

   localparam int FW = $clog2(LIFETIME_FRAMES + 1);
   localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [FW-1:0] WARN_AT    = FW'(LIFETIME_FRAMES - BLINK_FRAMES);
   localparam logic [FW-1:0] LIFE_END   = FW'(LIFETIME_FRAMES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

   localparam logic [1:0] ST_HIDDEN = 2'd0;
   localparam logic [1:0] ST_LIVE   = 2'd1;
   localparam logic [1:0] ST_WARN   = 2'd2;

   logic [1:0]            state;
   logic [FW-1:0]         frame_cnt;
   logic [FW-1:0]         frame_nxt;
   logic [BW-1:0]         blink_cnt;
   logic                  blink_vis;
   logic [9:0]            pos_x;
   logic [9:0]            pos_y;
   logic                  s1;
   logic                  s2;
   logic                  hit;
   logic                  opaque;
   logic [10:0]           px, py, x0, y0, dx, dy;
   logic [ADDR_WIDTH-1:0] addr_calc;

   // 11-bit compare so a sprite near the right/bottom edge never wraps to column/row 0
   always_comb begin
      px        = {1'b0, pixel_x};
      py        = {1'b0, pixel_y};
      x0        = {1'b0, pos_x};
      y0        = {1'b0, pos_y};
      dx        = px - x0;
      dy        = py - y0;
      hit       = (px >= x0) && (px < x0 + 11'(SPR_W)) &&
                  (py >= y0) && (py < y0 + 11'(SPR_H));
      addr_calc = ADDR_WIDTH'(dy) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(dx);
      opaque    = s2 && (rom_data != TRANSPARENT);
      frame_nxt = frame_cnt + FW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr         <= '0;
         s1               <= 1'b0;
         s2               <= 1'b0;
         food_pixel_valid <= 1'b0;
         food_rgb         <= '0;
      end else begin
         rom_addr         <= hit ? addr_calc : '0;
         s1               <= hit && food_active && blink_vis;
         s2               <= s1;
         food_pixel_valid <= opaque;
         food_rgb         <= opaque ? rom_data : '0;
      end
   end

   // Priority: spawn > eaten > frame_start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_HIDDEN;
         frame_cnt   <= '0;
         blink_cnt   <= '0;
         blink_vis   <= 1'b1;
         pos_x       <= '0;
         pos_y       <= '0;
         food_active <= 1'b0;
         expired     <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (spawn) begin
            state       <= ST_LIVE;
            food_active <= 1'b1;
            pos_x       <= spawn_x;
            pos_y       <= spawn_y;
            frame_cnt   <= '0;
            blink_cnt   <= '0;
            blink_vis   <= 1'b1;
         end else begin
            case (state)
               ST_HIDDEN: ;
               ST_LIVE: begin
                  if (eaten) begin
                     state       <= ST_HIDDEN;
                     food_active <= 1'b0;
                  end else if (frame_start) begin
                     frame_cnt <= frame_nxt;
                     if (frame_nxt == WARN_AT) begin
                        state     <= ST_WARN;
                        blink_cnt <= '0;
                        blink_vis <= 1'b1;
                     end
                  end
               end
               ST_WARN: begin
                  if (eaten) begin
                     state       <= ST_HIDDEN;
                     food_active <= 1'b0;
                  end else if (frame_start) begin
                     frame_cnt <= frame_nxt;
                     if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink_vis <= ~blink_vis;
                     end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                     end
                     if (frame_nxt == LIFE_END) begin
                        state       <= ST_HIDDEN;
                        food_active <= 1'b0;
                        expired     <= 1'b1;
                     end
                  end
               end
               default: begin
                  state       <= ST_HIDDEN;
                  food_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/food_sprite_renderer.md
Name: food_sprite_renderer

Overview:
- Drives the food sprite ROM: turns the current VGA pixel coordinate into a ROM address, then turns the returned 12-bit RGB word into a masked food pixel for the display mux.
- Owns the food lifecycle: spawn, live, expiry-warning blink, expire or eaten.
- Sits between the VGA sync/pixel counter and the food sprite ROM, which has a 1-cycle registered read. Its output goes to the top-level colour priority mux.

Parameters:
- DATA_WIDTH, 12, RGB word width (4:4:4); must match the ROM.
- ADDR_WIDTH, 20, ROM address width; must match the ROM.
- SPR_W, 40, sprite width in pixels.
- SPR_H, 20, sprite height in pixels; SPR_W*SPR_H must equal the ROM_SIZE of the attached ROM.
- TRANSPARENT, 12'h0F0, ROM colour treated as "no pixel".
- LIFETIME_FRAMES, 600, frames from spawn to expiry.
- BLINK_FRAMES, 180, final frames of the lifetime spent in the warning state. Must be less than LIFETIME_FRAMES.
- BLINK_PERIOD, 15, frames per blink half-period.

Ports:
- clk, input, 1, system/pixel clock.
- reset_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse at the start of each frame.
- pixel_x, input, 10, current pixel column.
- pixel_y, input, 10, current pixel row.
- spawn, input, 1, one-cycle pulse: place new food.
- spawn_x, input, 10, sprite top-left column, sampled on spawn.
- spawn_y, input, 10, sprite top-left row, sampled on spawn.
- eaten, input, 1, one-cycle pulse: food consumed.
- rom_addr, output, ADDR_WIDTH, address to the sprite ROM (registered).
- rom_data, input, DATA_WIDTH, ROM read data, valid 1 cycle after rom_addr.
- food_active, output, 1, high in LIVE or WARN.
- food_pixel_valid, output, 1, the pixel belongs to visible, opaque food.
- food_rgb, output, DATA_WIDTH, food colour; 0 when food_pixel_valid is low.
- expired, output, 1, one-cycle pulse when the lifetime elapses.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=HIDDEN; frame_cnt=0; blink_cnt=0; blink_vis=1; pos_x=pos_y=0.
  - rom_addr=0; all pipeline flags 0; food_active=0; food_pixel_valid=0; food_rgb=0; expired=0.
  - Reset mid-frame kills any in-flight pixels. The first valid output can appear 3 cycles after release.
- Hit test (combinational, 11-bit unsigned arithmetic so there is no wrap at the screen edge):
  - hit = (pixel_x >= pos_x) && (pixel_x < pos_x+SPR_W) && (pixel_y >= pos_y) && (pixel_y < pos_y+SPR_H).
  - A sprite placed partly off-screen renders only its on-screen part.
- Pipeline, with pixel coordinate presented in cycle t:
  - Edge t+1: rom_addr <= hit ? (pixel_y-pos_y)*SPR_W + (pixel_x-pos_x) : 0. Register s1 <= hit && food_active && blink_vis.
  - Edge t+2: ROM registers data; s2 <= s1.
  - Edge t+3: food_pixel_valid <= s2 && (rom_data != TRANSPARENT); food_rgb <= that condition ? rom_data : 0.
  - Total latency is 3 cycles, fixed, with no stalls. The VGA side delays its own pixel path by 3 cycles to align.
- FSM states: HIDDEN, LIVE, WARN.
- HIDDEN:
  - spawn -> LIVE; pos <= spawn_x/spawn_y; frame_cnt <= 0; blink_vis <= 1.
  - eaten is ignored.
- LIVE:
  - Each frame_start: frame_cnt+1.
  - When the incremented value equals LIFETIME_FRAMES-BLINK_FRAMES -> WARN; blink_cnt <= 0; blink_vis <= 1.
- WARN:
  - Each frame_start: frame_cnt+1 and blink_cnt+1.
  - When blink_cnt reaches BLINK_PERIOD-1 at a frame_start: blink_cnt <= 0 and blink_vis toggles.
  - When the incremented frame_cnt equals LIFETIME_FRAMES -> HIDDEN. expired=1 for exactly that cycle.
- Simultaneous events:
  - eaten in LIVE/WARN -> HIDDEN next edge; no expired pulse.
  - spawn in LIVE/WARN restarts as a spawn from HIDDEN: new position, frame_cnt=0, LIVE.
  - spawn together with eaten: spawn wins (restart).
  - spawn or eaten together with frame_start: spawn or eaten wins; the frame is not counted.
  - eaten on the expiry frame_start: eaten wins; no expired pulse.
- Position registers update immediately on spawn; mid-frame tearing is accepted.
- food_active is registered from state. It is included in s1, so pixels already in the pipeline drain with their captured flags.

Test Plan:
- Reset, then spawn at (100,200) and sweep pixel (100,200) -> rom_addr=0 at t+1. Pixel (139,219) -> rom_addr=799. Pixel (140,200) -> rom_addr=0 and food_pixel_valid=0 at t+3.
- Preload the ROM with word 5 = 12'hF00 and word 6 = 12'h0F0; present (105,200) and (106,200) -> food_rgb=12'hF00 with valid=1 at t+3, then valid=0 and rgb=0 at t+4.
- Use LIFETIME_FRAMES=10, BLINK_FRAMES=4, BLINK_PERIOD=2; spawn, then pulse frame_start 10 times:
  - WARN is entered after frame 6.
  - blink_vis toggles after frames 8 and 10.
  - expired pulses once on frame 10; food_active=0 afterwards.
- In WARN, assert spawn and eaten in the same cycle -> state LIVE, frame_cnt=0, food_active stays 1, no expired pulse.
- Spawn at (630,470) and sample pixel (639,479) -> rom_addr=9*40+9=369 and valid=1 if opaque. No hit for pixel (5,5), so there is no wrap.
- Drop reset_n mid-sprite while valid=1 -> food_pixel_valid, food_rgb, rom_addr and food_active are 0 immediately, with no clock edge needed.
